// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer_if
// Brief    : Opcode/flag inputs and control-word/step/halt outputs of the
//            CPU control sequencer, grouped for module-port use.
// Revision : 1.0 - initial release
// ============================================================================
interface control_sequencer_if #(
    parameter int STEP_W = 3
);
    logic [3:0]        opcode;
    logic              carry_flag;
    logic              zero_flag;
    logic [15:0]       ctrl;
    logic [STEP_W-1:0] step;
    logic              halted;

    modport master (
        input  opcode, carry_flag, zero_flag,
        output ctrl, step, halted
    );

    modport slave (
        output opcode, carry_flag, zero_flag,
        input  ctrl, step, halted
    );
endinterface
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Brief    : Microcoded T-state sequencer of the 8-bit CPU; decodes opcode,
//            step and latched flags into the 16-bit control word.
//            Optional EARLY_FETCH_EN: restart fetch after the last non-empty
//            step of each instruction instead of always running STEPS steps.
// Revision : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter int STEPS  = 5,
    parameter int STEP_W = 3
) (
    input  wire logic          clk,
    input  wire logic          bReset,
    control_sequencer_if.master bus
);

    localparam logic [15:0] c_HLT = 16'h8000;
    localparam logic [15:0] c_MI  = 16'h4000;
    localparam logic [15:0] c_RI  = 16'h2000;
    localparam logic [15:0] c_RO  = 16'h1000;
    localparam logic [15:0] c_IO  = 16'h0800;
    localparam logic [15:0] c_II  = 16'h0400;
    localparam logic [15:0] c_AI  = 16'h0200;
    localparam logic [15:0] c_AO  = 16'h0100;
    localparam logic [15:0] c_EO  = 16'h0080;
    localparam logic [15:0] c_SU  = 16'h0040;
    localparam logic [15:0] c_BI  = 16'h0020;
    localparam logic [15:0] c_OI  = 16'h0010;
    localparam logic [15:0] c_CE  = 16'h0008;
    localparam logic [15:0] c_CO  = 16'h0004;
    localparam logic [15:0] c_J   = 16'h0002;
    localparam logic [15:0] c_FI  = 16'h0001;

    localparam logic [3:0] c_OP_NOP = 4'b0000;
    localparam logic [3:0] c_OP_LDA = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0011;
    localparam logic [3:0] c_OP_STA = 4'b0100;
    localparam logic [3:0] c_OP_LDI = 4'b0101;
    localparam logic [3:0] c_OP_JMP = 4'b0110;
    localparam logic [3:0] c_OP_JC  = 4'b0111;
    localparam logic [3:0] c_OP_JZ  = 4'b1000;
    localparam logic [3:0] c_OP_OUT = 4'b1110;
    localparam logic [3:0] c_OP_HLT = 4'b1111;

    localparam logic [STEP_W-1:0] c_T0   = STEP_W'(0);
    localparam logic [STEP_W-1:0] c_T1   = STEP_W'(1);
    localparam logic [STEP_W-1:0] c_T2   = STEP_W'(2);
    localparam logic [STEP_W-1:0] c_T3   = STEP_W'(3);
    localparam logic [STEP_W-1:0] c_T4   = STEP_W'(4);
    localparam logic [STEP_W-1:0] c_LAST = STEP_W'(STEPS - 1);

    logic [STEP_W-1:0] r_step;
    logic              r_halted;
    logic [15:0]       w_ctrl;
    logic              w_restart;

    // Reset forces step 0, so the fetch word CO|MI appears while reset is held.
    always_comb begin
        w_ctrl = '0;
        if (r_halted) begin
            w_ctrl = c_HLT;
        end else if (r_step == c_T0) begin
            w_ctrl = c_CO | c_MI;
        end else if (r_step == c_T1) begin
            w_ctrl = c_RO | c_II | c_CE;
        end else if (r_step == c_T2) begin
            case (bus.opcode)
                c_OP_LDA, c_OP_ADD,
                c_OP_SUB, c_OP_STA: w_ctrl = c_IO | c_MI;
                c_OP_LDI:           w_ctrl = c_IO | c_AI;
                c_OP_JMP:           w_ctrl = c_IO | c_J;
                c_OP_JC:            w_ctrl = c_IO | (bus.carry_flag ? c_J : 16'h0000);
                c_OP_JZ:            w_ctrl = c_IO | (bus.zero_flag  ? c_J : 16'h0000);
                c_OP_OUT:           w_ctrl = c_AO | c_OI;
                c_OP_HLT:           w_ctrl = c_HLT;
                default:            w_ctrl = '0;
            endcase
        end else if (r_step == c_T3) begin
            case (bus.opcode)
                c_OP_LDA:           w_ctrl = c_RO | c_AI;
                c_OP_ADD, c_OP_SUB: w_ctrl = c_RO | c_BI;
                c_OP_STA:           w_ctrl = c_AO | c_RI;
                default:            w_ctrl = '0;
            endcase
        end else if (r_step == c_T4) begin
            case (bus.opcode)
                c_OP_ADD: w_ctrl = c_EO | c_AI | c_FI;
                c_OP_SUB: w_ctrl = c_EO | c_AI | c_SU | c_FI;
                default:  w_ctrl = '0;
            endcase
        end
    end

`ifdef EARLY_FETCH_EN
    logic [STEP_W-1:0] w_last_step;

    // HLT never reaches its "last step" edge: the halt freezes the counter first.
    always_comb begin
        case (bus.opcode)
            c_OP_LDI, c_OP_JMP, c_OP_JC,
            c_OP_JZ, c_OP_OUT:            w_last_step = c_T2;
            c_OP_LDA, c_OP_STA:           w_last_step = c_T3;
            c_OP_ADD, c_OP_SUB:           w_last_step = c_T4;
            c_OP_HLT:                     w_last_step = c_LAST;
            default:                      w_last_step = c_T1;
        endcase
    end

    assign w_restart = (r_step == c_LAST) || (r_step == w_last_step);
`else
    assign w_restart = (r_step == c_LAST);
`endif

    always_ff @(posedge clk or posedge bReset) begin
        if (bReset) begin
            r_step   <= '0;
            r_halted <= 1'b0;
        end else if (!r_halted) begin
            if (w_ctrl[15]) begin
                r_halted <= 1'b1;
            end else if (w_restart) begin
                r_step <= '0;
            end else begin
                r_step <= r_step + STEP_W'(1);
            end
        end
    end

    assign bus.ctrl   = w_ctrl;
    assign bus.step   = r_step;
    assign bus.halted = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_sequencer
// Brief    : Directed self-checking bench for control_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    localparam int STEPS  = 5;
    localparam int STEP_W = 3;

    logic clk    = 1'b0;
    logic bReset = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    control_sequencer_if #(.STEP_W(STEP_W)) bus ();

    control_sequencer #(.STEPS(STEPS), .STEP_W(STEP_W)) dut (
        .clk    (clk),
        .bReset (bReset),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    // Opcode, last checked step and expected ctrl per step, hand-decoded.
    logic [3:0]  tbl_op   [7] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'hE};
    int          tbl_last [7] = '{1, 3, 4, 3, 2, 2, 2};
    logic [15:0] tbl_ctrl [7][5] = '{
        '{16'h4004, 16'h1408, 16'h0000, 16'h0000, 16'h0000},
        '{16'h4004, 16'h1408, 16'h4800, 16'h1200, 16'h0000},
        '{16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0281},
        '{16'h4004, 16'h1408, 16'h4800, 16'h2100, 16'h0000},
        '{16'h4004, 16'h1408, 16'h0A00, 16'h0000, 16'h0000},
        '{16'h4004, 16'h1408, 16'h0802, 16'h0000, 16'h0000},
        '{16'h4004, 16'h1408, 16'h0110, 16'h0000, 16'h0000}
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bReset = 1'b1;
        #1;
        bReset = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if (bus.step !== 3'd0) begin
            $display("FAIL reset_step: got %0d expected 0", bus.step); n_fail++;
        end
        n_cmp++;
        if (bus.halted !== 1'b0) begin
            $display("FAIL reset_halted: got %b expected 0", bus.halted); n_fail++;
        end
        n_cmp++;
        if (bus.ctrl !== 16'h4004) begin
            $display("FAIL reset_ctrl: got %h expected 4004", bus.ctrl); n_fail++;
        end
        tick();
        bReset = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.opcode = 4'h2;
        repeat (3) tick();
        n_cmp++;
        if (bus.step !== 3'd3) begin
            $display("FAIL async_pre_step: got %0d expected 3", bus.step); n_fail++;
        end
        #1 bReset = 1'b1;
        #1;
        n_cmp++;
        if (bus.step !== 3'd0 || bus.halted !== 1'b0 || bus.ctrl !== 16'h4004) begin
            $display("FAIL async_reset: got step=%0d halted=%b ctrl=%h expected 0 0 4004",
                     bus.step, bus.halted, bus.ctrl);
            n_fail++;
        end
        bReset = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (bus.step !== 3'd2) begin
            $display("FAIL async_release_step: got %0d expected 2", bus.step); n_fail++;
        end
    endtask

    task automatic test_sub();
        logic [15:0] exp_c [5] = '{16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h02C1};
        do_reset();
        bus.opcode = 4'h3;
        for (int s = 0; s < 5; s++) begin
            n_cmp++;
            if (bus.step !== 3'(s) || bus.ctrl !== exp_c[s]) begin
                $display("FAIL sub_t%0d: got step=%0d ctrl=%h expected step=%0d ctrl=%h",
                         s, bus.step, bus.ctrl, s, exp_c[s]);
                n_fail++;
            end
            tick();
        end
        n_cmp++;
        if (bus.step !== 3'd0) begin
            $display("FAIL sub_wrap: got %0d expected 0", bus.step); n_fail++;
        end
    endtask

    task automatic test_cond_jumps();
        logic [15:0] got;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            bus.opcode     = (k == 0) ? 4'h7 : 4'h8;
            bus.carry_flag = 1'b0;
            bus.zero_flag  = 1'b0;
            tick();
            tick();
            n_cmp++;
            if (bus.ctrl !== 16'h0800) begin
                $display("FAIL jump%0d_not_taken: got %h expected 0800", k, bus.ctrl); n_fail++;
            end
            // The other flag must not cause the jump.
            if (k == 0) bus.zero_flag = 1'b1; else bus.carry_flag = 1'b1;
            #1;
            n_cmp++;
            if (bus.ctrl !== 16'h0800) begin
                $display("FAIL jump%0d_wrong_flag: got %h expected 0800", k, bus.ctrl); n_fail++;
            end
            if (k == 0) bus.carry_flag = 1'b1; else bus.zero_flag = 1'b1;
            #1;
            got = bus.ctrl;
            n_cmp++;
            if (got !== 16'h0802) begin
                $display("FAIL jump%0d_taken: got %h expected 0802", k, got); n_fail++;
            end
            bus.carry_flag = 1'b0;
            bus.zero_flag  = 1'b0;
        end
    endtask

    task automatic test_opcode_table();
        for (int e = 0; e < 7; e++) begin
            do_reset();
            bus.opcode = tbl_op[e];
            for (int s = 0; s <= tbl_last[e]; s++) begin
                n_cmp++;
                if (bus.step !== 3'(s) || bus.ctrl !== tbl_ctrl[e][s]) begin
                    $display("FAIL op%h_t%0d: got step=%0d ctrl=%h expected step=%0d ctrl=%h",
                             tbl_op[e], s, bus.step, bus.ctrl, s, tbl_ctrl[e][s]);
                    n_fail++;
                end
                tick();
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        bus.opcode = 4'hF;
        tick();
        tick();
        n_cmp++;
        if (bus.ctrl !== 16'h8000 || bus.halted !== 1'b0) begin
            $display("FAIL halt_t2: got ctrl=%h halted=%b expected 8000 0", bus.ctrl, bus.halted);
            n_fail++;
        end
        tick();
        bus.opcode = 4'h0;
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (bus.halted !== 1'b1 || bus.step !== 3'd2 || bus.ctrl !== 16'h8000) begin
                $display("FAIL halt_hold%0d: got halted=%b step=%0d ctrl=%h expected 1 2 8000",
                         i, bus.halted, bus.step, bus.ctrl);
                n_fail++;
            end
            tick();
        end
        bReset = 1'b1;
        #1;
        n_cmp++;
        if (bus.halted !== 1'b0 || bus.step !== 3'd0 || bus.ctrl !== 16'h4004) begin
            $display("FAIL halt_exit: got halted=%b step=%0d ctrl=%h expected 0 0 4004",
                     bus.halted, bus.step, bus.ctrl);
            n_fail++;
        end
        bReset = 1'b0;
    endtask

    task automatic test_ldi_length();
`ifdef EARLY_FETCH_EN
        int          exp_s [6] = '{0, 1, 2, 0, 1, 2};
        logic [15:0] exp_c [6] = '{16'h4004, 16'h1408, 16'h0A00, 16'h4004, 16'h1408, 16'h0A00};
`else
        int          exp_s [6] = '{0, 1, 2, 3, 4, 0};
        logic [15:0] exp_c [6] = '{16'h4004, 16'h1408, 16'h0A00, 16'h0000, 16'h0000, 16'h4004};
`endif
        do_reset();
        bus.opcode = 4'h5;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (bus.step !== 3'(exp_s[i]) || bus.ctrl !== exp_c[i]) begin
                $display("FAIL ldi_cyc%0d: got step=%0d ctrl=%h expected step=%0d ctrl=%h",
                         i, bus.step, bus.ctrl, exp_s[i], exp_c[i]);
                n_fail++;
            end
            tick();
        end
    endtask

    task automatic test_unassigned();
        int          es;
        logic [15:0] ec;
        int          fi_seen = 0;
        do_reset();
        bus.opcode = 4'hA;
        for (int i = 0; i < 10; i++) begin
`ifdef EARLY_FETCH_EN
            es = i % 2;
`else
            es = i % 5;
`endif
            ec = (es == 0) ? 16'h4004 : (es == 1) ? 16'h1408 : 16'h0000;
            if (bus.ctrl[0] === 1'b1) fi_seen++;
            n_cmp++;
            if (bus.step !== 3'(es) || bus.ctrl !== ec) begin
                $display("FAIL unassigned_cyc%0d: got step=%0d ctrl=%h expected step=%0d ctrl=%h",
                         i, bus.step, bus.ctrl, es, ec);
                n_fail++;
            end
            tick();
        end
        n_cmp++;
        if (fi_seen !== 0) begin
            $display("FAIL unassigned_fi: got %0d FI cycles expected 0", fi_seen); n_fail++;
        end
    endtask

    initial begin
        bus.opcode     = 4'h0;
        bus.carry_flag = 1'b0;
        bus.zero_flag  = 1'b0;
        test_reset();
        test_async_reset();
        test_sub();
        test_cond_jumps();
        test_opcode_table();
        test_halt();
        test_ldi_length();
        test_unassigned();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
